// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width common to pwm_generator and its
// upstream ramp controller, plus the ramp controller state encoding.
package pwm_pkg;

  localparam int unsigned DUTY_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

endpackage

// File: rtl/ramp_tick_timer.sv
// Loadable down-counter pacing the ramp steps.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load counter with load_val (wins over en)
//   load_val  - reload value
//   en        - count down by one while nonzero
//   zero      - counter currently at zero (decoded from the register)
module ramp_tick_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Down-counter; saturates at zero until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Slew-rate limiter in front of pwm_generator: accepts a target duty over a
// valid/ready handshake and walks duty toward it in programmable steps at a
// programmable interval, with hold, busy and a one-cycle done pulse.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   tgt_valid  - target request valid
//   tgt_ready  - request can be accepted (registered)
//   tgt_duty   - requested final duty
//   step       - duty increment per step (0 treated as 1), sampled at accept
//   interval   - idle cycles between steps, sampled at accept
//   hold       - freeze timer, duty and state
//   duty       - registered duty output
//   busy       - ramp in progress (registered)
//   done       - one-cycle pulse when duty reaches the target (registered)
module duty_ramp_ctrl #(
  parameter int unsigned DUTY_W = 8,
  parameter int unsigned INTV_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic [DUTY_W-1:0] step,
  input  logic [INTV_W-1:0] interval,
  input  logic              hold,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  import pwm_pkg::*;

  ramp_state_t       state;
  logic [DUTY_W-1:0] tgt_q;
  logic [DUTY_W-1:0] step_q;
  logic [INTV_W-1:0] intv_q;
  logic              same_q;   // accepted target equalled duty; done follows

  logic              accept;
  logic [DUTY_W-1:0] step_eff;
  logic              dir_up;
  logic [DUTY_W:0]   diff;
  logic              last_step;
  logic              step_due;
  logic              tmr_en;
  logic              tmr_load;
  logic [INTV_W-1:0] tmr_load_val;
  logic              tmr_zero;

  assign accept   = tgt_valid && tgt_ready;
  assign step_eff = (step == '0) ? DUTY_W'(1) : step;

  // Distance to target in one extra bit so the compare against step is exact.
  assign dir_up    = (tgt_q >= duty);
  assign diff      = dir_up ? ({1'b0, tgt_q} - {1'b0, duty})
                            : ({1'b0, duty} - {1'b0, tgt_q});
  assign last_step = (diff <= {1'b0, step_q});

  assign tmr_en       = (state == RAMP) && !hold;
  assign step_due     = tmr_en && tmr_zero;
  assign tmr_load     = accept || (step_due && !last_step);
  assign tmr_load_val = accept ? interval : intv_q;

  ramp_tick_timer #(
    .W (INTV_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Ramp FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tgt_q     <= '0;
      step_q    <= '0;
      intv_q    <= '0;
      same_q    <= 1'b0;
      duty      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tgt_ready <= 1'b1;
    end else begin
      done   <= 1'b0;
      same_q <= 1'b0;
      case (state)
        IDLE: begin
          if (same_q) begin
            done <= 1'b1;
          end
          if (accept) begin
            tgt_q  <= tgt_duty;
            step_q <= step_eff;
            intv_q <= interval;
            if (tgt_duty == duty) begin
              same_q <= 1'b1;
            end else begin
              state     <= RAMP;
              busy      <= 1'b1;
              tgt_ready <= 1'b0;
            end
          end
        end
        RAMP: begin
          if (step_due) begin
            if (last_step) begin
              duty      <= tgt_q;
              done      <= 1'b1;
              busy      <= 1'b0;
              tgt_ready <= 1'b1;
              state     <= IDLE;
            end else if (dir_up) begin
              duty <= duty + step_q;
            end else begin
              duty <= duty - step_q;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          tgt_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl with hand-computed expected values.
module tb_duty_ramp_ctrl;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned INTV_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              tgt_valid;
  logic              tgt_ready;
  logic [DUTY_W-1:0] tgt_duty;
  logic [DUTY_W-1:0] step;
  logic [INTV_W-1:0] interval;
  logic              hold;
  logic [DUTY_W-1:0] duty;
  logic              busy;
  logic              done;

  int n_chk  = 0;
  int n_pass = 0;

  duty_ramp_ctrl #(
    .DUTY_W (DUTY_W),
    .INTV_W (INTV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_duty  (tgt_duty),
    .step      (step),
    .interval  (interval),
    .hold      (hold),
    .duty      (duty),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request; returns just after the accepting edge N.
  task automatic request(input int td, input int st, input int iv);
    check("req_ready", int'(tgt_ready), 1);
    tgt_valid = 1'b1;
    tgt_duty  = DUTY_W'(td);
    step      = DUTY_W'(st);
    interval  = INTV_W'(iv);
    tick();
    tgt_valid = 1'b0;
  endtask

  // Jump duty straight to a value with a full-range step.
  task automatic preset(input int td);
    request(td, 255, 0);
    tick();
    check("preset_duty", int'(duty), td);
    check("preset_done", int'(done), 1);
    tick();
  endtask

  int exp_dn [4] = '{136, 72, 8, 0};
  int exp_d;

  initial begin
    rst = 1'b1; tgt_valid = 1'b0; tgt_duty = '0; step = '0;
    interval = '0; hold = 1'b0;
    tick(); tick();
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(tgt_ready), 1);
    rst = 1'b0;
    tick();

    // Ramp up 0 -> 64, step 16, interval 3
    request(64, 16, 3);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("up_duty@%0d", k), int'(duty), 16 * (k / 4));
      check($sformatf("up_done@%0d", k), int'(done), (k == 16) ? 1 : 0);
      check($sformatf("up_busy@%0d", k), int'(busy), (k < 16) ? 1 : 0);
    end
    tick();
    check("up_done_clear", int'(done), 0);

    // Ramp down 200 -> 0, step 64, interval 0, last step clamps
    preset(200);
    request(0, 64, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("dn_duty@%0d", k), int'(duty), exp_dn[k-1]);
      check($sformatf("dn_done@%0d", k), int'(done), (k == 4) ? 1 : 0);
    end
    tick();

    // Top clamp 250 -> 255 with step 16
    preset(250);
    request(255, 16, 0);
    tick();
    check("top_duty", int'(duty), 255);
    check("top_done", int'(done), 1);
    tick();

    // Zero step treated as one
    preset(0);
    request(3, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("z_duty@%0d", k), int'(duty), k);
      check($sformatf("z_done@%0d", k), int'(done), (k == 3) ? 1 : 0);
    end
    tick();

    // Same target: done at N+1, busy stays low
    preset(128);
    request(128, 16, 0);
    check("same_busy@0", int'(busy), 0);
    check("same_done@0", int'(done), 0);
    tick();
    check("same_done@1", int'(done), 1);
    check("same_busy@1", int'(busy), 0);
    check("same_duty@1", int'(duty), 128);
    tick();
    check("same_done@2", int'(done), 0);
    check("same_busy@2", int'(busy), 0);

    // Hold for edges N+2..N+6 delays every step by 5; a pending request
    // raised at N+10 must wait for the handshake
    preset(0);
    request(64, 16, 3);
    for (int k = 1; k <= 21; k++) begin
      hold = (k >= 2 && k <= 6);
      if (k >= 10) begin
        tgt_valid = 1'b1; tgt_duty = '0; step = 8'd255; interval = '0;
      end
      tick();
      exp_d = (k < 9) ? 0 : 16 * (1 + (k - 9) / 4);
      check($sformatf("hold_duty@%0d", k), int'(duty), exp_d);
      check($sformatf("hold_done@%0d", k), int'(done), (k == 21) ? 1 : 0);
      check($sformatf("hold_ready@%0d", k), int'(tgt_ready), (k == 21) ? 1 : 0);
    end
    hold = 1'b0;
    tick();
    tgt_valid = 1'b0;
    check("bp_busy", int'(busy), 1);
    check("bp_ready", int'(tgt_ready), 0);
    tick();
    check("bp_duty", int'(duty), 0);
    check("bp_done", int'(done), 1);
    tick();

    // Reset mid-ramp at duty 48
    request(64, 16, 3);
    for (int k = 1; k <= 12; k++) tick();
    check("mid_duty_pre", int'(duty), 48);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_duty", int'(duty), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_ready", int'(tgt_ready), 1);
    for (int k = 1; k <= 5; k++) tick();
    check("mid_duty_after", int'(duty), 0);
    check("mid_busy_after", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
